// File: rtl/counter_check_pkg.sv
// Shared types, defaults and the next-value reference function for the
// load/count checker.
package counter_check_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_NUM_CHECKS = 200;
    localparam int DEF_ERR_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // How the reference model updates its expected value this cycle.
    typedef enum logic [1:0] {
        MODEL_HOLD    = 2'd0,
        MODEL_SYNC    = 2'd1,
        MODEL_PREDICT = 2'd2
    } model_mode_t;

    // Load wins over increment; the caller truncates to its own width,
    // which gives the modulo-2^WIDTH wrap.
    function automatic logic [31:0] predict(input logic        ld,
                                            input logic [31:0] init,
                                            input logic [31:0] prev);
        return ld ? init : prev + 32'd1;
    endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Reference model for the counter: holds the expected next count and
// updates it by sync (from observed count), predict (from itself) or hold.
module counter_ref_model
    import counter_check_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  model_mode_t      mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] init,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] exp_val
);

    logic [WIDTH-1:0] exp_nxt;

    always_comb begin
        exp_nxt = exp_val;
        case (mode)
            MODEL_SYNC:    exp_nxt = WIDTH'(predict(ld, 32'(init), 32'(count)));
            MODEL_PREDICT: exp_nxt = WIDTH'(predict(ld, 32'(init), 32'(exp_val)));
            default:       exp_nxt = exp_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_val <= '0;
        end else begin
            exp_val <= exp_nxt;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Monitor for a load/increment counter: compares the observed count against
// a reference model for NUM_CHECKS cycles and reports a done/pass verdict.
module counter_checker
    import counter_check_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NUM_CHECKS = DEF_NUM_CHECKS,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ld,
    input  logic [WIDTH-1:0] init,
    input  logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_iter,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_act,
    output logic             done,
    output logic             pass,
    output chk_state_t       dbg_state
);

    chk_state_t       state, state_nxt;
    model_mode_t      mode;
    logic [WIDTH-1:0] exp_val;
    logic [15:0]      iter;
    logic             run_start;
    logic             cmp_fail;

    counter_ref_model #(.WIDTH(WIDTH)) u_model (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .ld      (ld),
        .init    (init),
        .count   (count),
        .exp_val (exp_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A failed compare resyncs the model from the observed count so a single
    // fault is reported once rather than on every following cycle.
    always_comb begin
        state_nxt = state;
        mode      = MODEL_HOLD;
        run_start = 1'b0;
        cmp_fail  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SYNC;
                    run_start = 1'b1;
                end
            end
            SYNC: begin
                state_nxt = CHECK;
                mode      = MODEL_SYNC;
            end
            CHECK: begin
                cmp_fail = (count != exp_val);
                mode     = cmp_fail ? MODEL_SYNC : MODEL_PREDICT;
                if (iter == 16'(NUM_CHECKS - 1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch       <= 1'b0;
            iter           <= '0;
            err_count      <= '0;
            first_err_iter <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else begin
            mismatch <= cmp_fail;
            if (run_start) begin
                iter           <= '0;
                err_count      <= '0;
                first_err_iter <= '0;
                first_err_exp  <= '0;
                first_err_act  <= '0;
            end else if (state == CHECK) begin
                iter <= iter + 16'd1;
                if (cmp_fail) begin
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                    if (err_count == '0) begin
                        first_err_iter <= iter;
                        first_err_exp  <= exp_val;
                        first_err_act  <= count;
                    end
                end
            end
        end
    end

    assign busy      = (state == SYNC) || (state == CHECK);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == '0);
    assign dbg_state = state;

endmodule
